// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: instruction opcodes, sequencer state encoding and the
// default no-op word issued whenever the sequencer has nothing to send.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_ALU = 2'd0,
        OP_LD  = 2'd1,
        OP_ST  = 2'd2,
        OP_BR  = 2'd3
    } opcode_e;

    typedef struct packed {
        opcode_e    opcode;
        logic [1:0] reg0_addr;
        logic [1:0] reg1_addr;
        logic [1:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam logic [7:0] NOP_INSTR_DEFAULT = 8'h00;
    localparam int         PROG_LEN_W        = 5;

endpackage

// File: rtl/instr_sequencer_if.sv
// Host/core side signals of the instruction sequencer; master = host and core,
// slave = sequencer.
interface instr_sequencer_if;

    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       clear;
    logic       start;
    logic       halt;
    logic       redirect;
    logic [7:0] redirect_addr;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       busy;
    logic       done;
    logic [instr_sequencer_pkg::PROG_LEN_W-1:0] prog_len;

    modport master (
        output load_valid, load_data, clear, start, halt, redirect, redirect_addr,
        input  load_ready, instr_out, instr_valid, busy, done, prog_len
    );

    modport slave (
        input  load_valid, load_data, clear, start, halt, redirect, redirect_addr,
        output load_ready, instr_out, instr_valid, busy, done, prog_len
    );

endinterface

// File: rtl/instr_sequencer_prog_mem.sv
// Program buffer: DEPTH x 8 register file, synchronous write, combinational read.
// Storage is deliberately not reset; prog_len gates what is reachable.
module instr_sequencer_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Buffers a host-loaded program and streams it to the core, one word per cycle,
// first word one cycle after start; loads are refused while running or full.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = PROG_LEN_W;

    seq_state_e    state_q, state_d;
    logic [LW-1:0] prog_len_q, prog_len_d;
    logic [AW-1:0] fetch_ptr_q, fetch_ptr_d;
    logic          last_q, last_d;
    logic [7:0]    instr_q, instr_d;
    logic          valid_q, valid_d;

    logic          load_rdy;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW-1:0] redir_tgt;
    logic          unused_redirect_hi;

    assign load_rdy           = (state_q != ST_RUN) && (prog_len_q < LW'(DEPTH));
    assign redir_tgt          = bus.redirect_addr[AW-1:0];
    assign unused_redirect_hi = ^bus.redirect_addr[7:AW];

    instr_sequencer_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_prog_mem (
        .clk   (clk),
        .we    (wr_en & rst_n),
        .waddr (prog_len_q[AW-1:0]),
        .wdata (bus.load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prog_len_q  <= '0;
            fetch_ptr_q <= '0;
            last_q      <= 1'b0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_len_q  <= prog_len_d;
            fetch_ptr_q <= fetch_ptr_d;
            last_q      <= last_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
        end
    end

    // last_q marks that entry prog_len-1 was the word just issued; needed because
    // fetch_ptr wraps to 0 when the buffer is completely full.
    always_comb begin
        state_d     = state_q;
        prog_len_d  = prog_len_q;
        fetch_ptr_d = fetch_ptr_q;
        last_d      = last_q;
        instr_d     = NOP_INSTR;
        valid_d     = 1'b0;
        wr_en       = 1'b0;
        rd_addr     = (state_q == ST_RUN) ? fetch_ptr_q : '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.clear) begin
                    prog_len_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    if (bus.load_valid && load_rdy) begin
                        wr_en      = 1'b1;
                        prog_len_d = prog_len_q + LW'(1);
                    end
                    if (bus.start && (prog_len_q != '0)) begin
                        state_d     = ST_RUN;
                        instr_d     = rd_data;
                        valid_d     = 1'b1;
                        fetch_ptr_d = AW'(1);
                        last_d      = (prog_len_d == LW'(1));
                    end
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    state_d = ST_IDLE;
                end else if (bus.redirect) begin
                    fetch_ptr_d = redir_tgt;
                    last_d      = 1'b0;
                    if (LW'(redir_tgt) >= prog_len_q) begin
                        state_d = ST_DONE;
                    end
                end else if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    instr_d     = rd_data;
                    valid_d     = 1'b1;
                    fetch_ptr_d = fetch_ptr_q + AW'(1);
                    last_d      = (LW'(fetch_ptr_q) == prog_len_q - LW'(1));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.load_ready  = load_rdy;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = (state_q == ST_RUN);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.prog_len    = prog_len_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: vector table, directed corner sequences and a
// randomized run against a queue-based model of the issued instruction stream.
module tb_instr_sequencer;

    localparam int         DEPTH = 16;
    localparam logic [7:0] NOP   = 8'hEE;
    localparam bit         H     = 1'b1;
    localparam bit         L     = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_sequencer_if bus();

    instr_sequencer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic       clr, st, hlt, rd;
        logic [7:0] ra;
        logic       lrdy;
        logic [4:0] len;
        logic       iv;
        logic [7:0] io;
        logic       busy, done;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(bit lv, logic [7:0] ld, bit clr, bit st, bit hlt, bit rd,
                                logic [7:0] ra, bit lrdy, logic [4:0] len, bit iv,
                                logic [7:0] io, bit busy, bit done);
        vec_t v;
        v.lv = lv; v.ld = ld; v.clr = clr; v.st = st; v.hlt = hlt; v.rd = rd; v.ra = ra;
        v.lrdy = lrdy; v.len = len; v.iv = iv; v.io = io; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid    = 1'b0;
        bus.load_data     = 8'h00;
        bus.clear         = 1'b0;
        bus.start         = 1'b0;
        bus.halt          = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 8'h00;
    endtask

    task automatic check_out(input string name, input bit v, input logic [7:0] d,
                             input bit b, input bit dn);
        check({name, "/instr"}, 32'({bus.instr_valid, bus.instr_out}), 32'({v, d}));
        check({name, "/state"}, 32'({bus.busy, bus.done}), 32'({b, dn}));
    endtask

    task automatic load_word(input logic [7:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic clear_buf();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    logic [7:0] prog [$];
    int         n, pos;
    bit         running, ev, eb, ed;
    logic [7:0] edat;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        bus.load_valid = 1'b1;
        bus.start      = 1'b1;
        tick();
        tick();
        check_out("reset", L, NOP, L, L);
        check("reset/len", 32'(bus.prog_len), 32'd0);
        check("reset/load_ready", 32'(bus.load_ready), 32'd1);
        idle_inputs();
        rst_n = 1'b1;

        // Load/clear/start/halt/redirect behaviour, one record per clock edge.
        tbl[0]  = mk(H, 8'h41, L, L, L, L, 8'h00, H, 5'd1, L, NOP,   L, L);
        tbl[1]  = mk(H, 8'h52, H, L, L, L, 8'h00, H, 5'd0, L, NOP,   L, L);
        tbl[2]  = mk(L, 8'h00, L, H, L, L, 8'h00, H, 5'd0, L, NOP,   L, L);
        tbl[3]  = mk(H, 8'h41, L, L, L, L, 8'h00, H, 5'd1, L, NOP,   L, L);
        tbl[4]  = mk(H, 8'h52, L, L, L, L, 8'h00, H, 5'd2, L, NOP,   L, L);
        tbl[5]  = mk(H, 8'h63, L, L, L, L, 8'h00, H, 5'd3, L, NOP,   L, L);
        tbl[6]  = mk(H, 8'h74, L, L, L, L, 8'h00, H, 5'd4, L, NOP,   L, L);
        tbl[7]  = mk(L, 8'h00, L, H, L, L, 8'h00, L, 5'd4, H, 8'h41, H, L);
        tbl[8]  = mk(H, 8'h99, L, L, L, L, 8'h00, L, 5'd4, H, 8'h52, H, L);
        tbl[9]  = mk(L, 8'h00, H, L, L, L, 8'h00, L, 5'd4, H, 8'h63, H, L);
        tbl[10] = mk(L, 8'h00, L, L, L, L, 8'h00, L, 5'd4, H, 8'h74, H, L);
        tbl[11] = mk(L, 8'h00, L, L, L, L, 8'h00, H, 5'd4, L, NOP,   L, H);
        tbl[12] = mk(L, 8'h00, L, H, L, L, 8'h00, L, 5'd4, H, 8'h41, H, L);
        tbl[13] = mk(L, 8'h00, L, H, H, H, 8'h02, H, 5'd4, L, NOP,   L, L);
        tbl[14] = mk(L, 8'h00, L, H, L, L, 8'h00, L, 5'd4, H, 8'h41, H, L);
        tbl[15] = mk(L, 8'h00, L, L, L, L, 8'h00, L, 5'd4, H, 8'h52, H, L);
        tbl[16] = mk(L, 8'h00, L, L, L, H, 8'h07, H, 5'd4, L, NOP,   L, H);
        tbl[17] = mk(L, 8'h00, H, L, L, L, 8'h00, H, 5'd0, L, NOP,   L, L);
        tbl[18] = mk(L, 8'h00, L, H, L, L, 8'h00, H, 5'd0, L, NOP,   L, L);

        for (int i = 0; i < 19; i++) begin
            bus.load_valid    = tbl[i].lv;
            bus.load_data     = tbl[i].ld;
            bus.clear         = tbl[i].clr;
            bus.start         = tbl[i].st;
            bus.halt          = tbl[i].hlt;
            bus.redirect      = tbl[i].rd;
            bus.redirect_addr = tbl[i].ra;
            tick();
            check($sformatf("vec%0d", i),
                  32'({bus.load_ready, bus.prog_len, bus.instr_valid, bus.instr_out, bus.busy, bus.done}),
                  32'({tbl[i].lrdy, tbl[i].len, tbl[i].iv, tbl[i].io, tbl[i].busy, tbl[i].done}));
            idle_inputs();
        end

        // Full buffer: 17th word refused, all 16 issued across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) load_word(8'hA0 + 8'(i));
        check("full/len", 32'(bus.prog_len), 32'd16);
        check("full/load_ready", 32'(bus.load_ready), 32'd0);
        load_word(8'hFF);
        check("full17/len", 32'(bus.prog_len), 32'd16);
        check("full17/load_ready", 32'(bus.load_ready), 32'd0);
        start_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            check_out($sformatf("full_issue%0d", i), H, 8'hA0 + 8'(i), H, L);
            tick();
        end
        check_out("full_done", L, NOP, L, H);

        // Redirect to 8'h12 on the third issue of an 8-word program.
        clear_buf();
        for (int i = 0; i < 8; i++) load_word(8'h10 + 8'(i));
        start_pulse();
        check_out("redir_w0", H, 8'h10, H, L);
        tick();
        check_out("redir_w1", H, 8'h11, H, L);
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'h12;
        tick();
        idle_inputs();
        check_out("redir_bubble", L, NOP, H, L);
        for (int i = 2; i < 8; i++) begin
            tick();
            check_out($sformatf("redir_w%0d", i), H, 8'h10 + 8'(i), H, L);
        end
        tick();
        check_out("redir_done", L, NOP, L, H);

        // Redirect beyond the program end.
        clear_buf();
        for (int i = 0; i < 5; i++) load_word(8'h20 + 8'(i));
        start_pulse();
        check_out("oob_w0", H, 8'h20, H, L);
        bus.redirect = 1'b1;
        bus.redirect_addr = 8'h07;
        tick();
        idle_inputs();
        check_out("oob_done", L, NOP, L, H);
        tick();
        check_out("oob_stay", L, NOP, L, H);

        // Reset in the middle of a run; a start before reloading is ignored.
        clear_buf();
        for (int i = 0; i < 4; i++) load_word(8'h30 + 8'(i));
        start_pulse();
        tick();
        check_out("rst_pre", H, 8'h31, H, L);
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data = 8'h55;
        tick();
        check_out("rst_mid", L, NOP, L, L);
        check("rst_mid/len", 32'(bus.prog_len), 32'd0);
        rst_n = 1'b1;
        bus.load_valid = 1'b0;
        tick();
        idle_inputs();
        check_out("rst_start_ignored", L, NOP, L, L);
        check("rst_start/len", 32'(bus.prog_len), 32'd0);

        // Random programs with random redirects, halts and ignored RUN-time inputs.
        for (int ep = 0; ep < 40; ep++) begin
            clear_buf();
            prog.delete();
            n = $urandom_range(1, DEPTH);
            while (prog.size() < n) begin
                bus.load_valid = ($urandom_range(0, 3) != 0);
                bus.load_data  = 8'($urandom);
                if (bus.load_valid) prog.push_back(bus.load_data);
                tick();
            end
            bus.load_valid = 1'b0;
            check("rnd_len", 32'(bus.prog_len), 32'(n));
            start_pulse();
            check_out("rnd_first", H, prog[0], H, L);
            pos = 1;
            running = 1'b1;
            for (int c = 0; c < 80 && running; c++) begin
                bus.halt          = ($urandom_range(0, 24) == 0) || (c == 79);
                bus.redirect      = ($urandom_range(0, 5) == 0);
                bus.redirect_addr = 8'($urandom);
                bus.start         = 1'($urandom_range(0, 1));
                bus.clear         = ($urandom_range(0, 7) == 0);
                bus.load_valid    = 1'($urandom_range(0, 1));
                bus.load_data     = 8'($urandom);
                ev = 1'b0; edat = NOP; eb = 1'b1; ed = 1'b0;
                if (bus.halt) begin
                    eb = 1'b0;
                    running = 1'b0;
                end else if (bus.redirect) begin
                    pos = int'(bus.redirect_addr) % DEPTH;
                    if (pos >= n) begin
                        eb = 1'b0; ed = 1'b1; running = 1'b0;
                    end
                end else if (pos >= n) begin
                    eb = 1'b0; ed = 1'b1; running = 1'b0;
                end else begin
                    ev = 1'b1; edat = prog[pos]; pos++;
                end
                tick();
                check_out($sformatf("rnd%0d_c%0d", ep, c), ev, edat, eb, ed);
            end
            idle_inputs();
            check("rnd_len_kept", 32'(bus.prog_len), 32'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
